// File: rtl/sort_pkg.sv
// Shared types and helpers for the pipelined odd-even transposition sorter.
package sort_pkg;

    typedef enum logic {
        SORT_ASC,
        SORT_DESC
    } sort_dir_e;

    // Width of an element's original-position tag.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sort_cas.sv
// One compare-and-swap cell: orders a pair of keys, carrying their position tags along.
module sort_cas
    import sort_pkg::*;
#(
    parameter int unsigned W          = 32,
    parameter int unsigned DESCENDING = 0,
    parameter int unsigned IDX_W      = 3
) (
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [IDX_W-1:0] b_idx,
    output logic [W-1:0]     lo,
    output logic [W-1:0]     hi,
    output logic [IDX_W-1:0] lo_idx,
    output logic [IDX_W-1:0] hi_idx
);

    localparam sort_dir_e DIR = (DESCENDING != 0) ? SORT_DESC : SORT_ASC;

    logic key_out_of_order;
    logic tie_out_of_order;
    logic swap;

    // Equal keys only move when the tags say they are out of input order.
    always_comb begin
        key_out_of_order = (DIR == SORT_DESC) ? (a < b) : (a > b);
        tie_out_of_order = (a == b) && (a_idx > b_idx);
        swap             = key_out_of_order || tie_out_of_order;
        lo               = swap ? b : a;
        hi               = swap ? a : b;
        lo_idx           = swap ? b_idx : a_idx;
        hi_idx           = swap ? a_idx : b_idx;
    end

endmodule

// File: rtl/sort_pipe_n.sv
// N-input pipelined odd-even transposition sorter with valid/ready flow control.
// Define SORT_INDEX_EN to carry original-position tags and expose out_idx.
module sort_pipe_n
    import sort_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned W          = 32,
    parameter int unsigned DESCENDING = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*W-1:0]   out_data
`ifdef SORT_INDEX_EN
    ,
    output logic [N*idx_w(N)-1:0] out_idx
`endif
);

    localparam int unsigned IW = idx_w(N);

    typedef logic [W-1:0]  data_t;
    typedef logic [IW-1:0] tag_t;

    logic         adv;
    logic [N-1:0] stage_v;
    data_t        stage_d [N][N];
    data_t        lin_d   [N][N];
    data_t        lout_d  [N][N];
    tag_t         lin_t   [N][N];
    tag_t         lout_t  [N][N];
`ifdef SORT_INDEX_EN
    tag_t         stage_t [N][N];
`endif

    assign out_valid = stage_v[N-1];
    assign adv       = !stage_v[N-1] || out_ready;
    assign in_ready  = adv;

    for (genvar s = 0; s < N; s++) begin : g_stage
        for (genvar i = 0; i < N; i++) begin : g_slot
            if (s == 0) begin : g_first
                assign lin_d[s][i] = in_data[i*W +: W];
            end else begin : g_next
                assign lin_d[s][i] = stage_d[s-1][i];
            end

`ifdef SORT_INDEX_EN
            if (s == 0) begin : g_tag_first
                assign lin_t[s][i] = tag_t'(i);
            end else begin : g_tag_next
                assign lin_t[s][i] = stage_t[s-1][i];
            end
`else
            assign lin_t[s][i] = '0;
`endif

            // Slot i opens a pair on layers of matching parity; a slot closing a pair is driven by that cell.
            if ((i % 2 == s % 2) && (i + 1 < N)) begin : g_cas
                sort_cas #(
                    .W          (W),
                    .DESCENDING (DESCENDING),
                    .IDX_W      (IW)
                ) u_cas (
                    .a      (lin_d[s][i]),
                    .b      (lin_d[s][i+1]),
                    .a_idx  (lin_t[s][i]),
                    .b_idx  (lin_t[s][i+1]),
                    .lo     (lout_d[s][i]),
                    .hi     (lout_d[s][i+1]),
                    .lo_idx (lout_t[s][i]),
                    .hi_idx (lout_t[s][i+1])
                );
            end else if (!((i >= 1) && ((i - 1) % 2 == s % 2))) begin : g_pass
                assign lout_d[s][i] = lin_d[s][i];
                assign lout_t[s][i] = lin_t[s][i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_v <= '0;
            for (int unsigned s = 0; s < N; s++)
                for (int unsigned i = 0; i < N; i++)
                    stage_d[s][i] <= '0;
        end else if (adv) begin
            stage_v <= {stage_v[N-2:0], in_valid};
            for (int unsigned s = 0; s < N; s++)
                for (int unsigned i = 0; i < N; i++)
                    stage_d[s][i] <= lout_d[s][i];
        end
    end

`ifdef SORT_INDEX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < N; s++)
                for (int unsigned i = 0; i < N; i++)
                    stage_t[s][i] <= '0;
        end else if (adv) begin
            for (int unsigned s = 0; s < N; s++)
                for (int unsigned i = 0; i < N; i++)
                    stage_t[s][i] <= lout_t[s][i];
        end
    end
`else
    // Tags are constant zero in this build; this sink is optimised away.
    logic tags_unused;
    always_comb begin
        tags_unused = 1'b0;
        for (int unsigned s = 0; s < N; s++)
            for (int unsigned i = 0; i < N; i++)
                tags_unused = tags_unused ^ (^lout_t[s][i]);
    end
`endif

    for (genvar i = 0; i < N; i++) begin : g_out
        assign out_data[i*W +: W] = stage_d[N-1][i];
`ifdef SORT_INDEX_EN
        assign out_idx[i*IW +: IW] = stage_t[N-1][i];
`endif
    end

endmodule
